// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and its array.
// The state encoding is visible on resp_state for debug.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 16;
  localparam int WAIT_W         = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with a registered read port.
// The storage is never reset; only the read register is.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // clr forces the read register to zero so illegal accesses return no stale data
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts read/write strobes, inserts wait states,
// touches the array on the edge entering RESPOND and pulses resp_ready.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_ready,
  output logic              resp_err,
  output logic              resp_busy,
  output logic [1:0]        resp_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t              state;
  logic [WAIT_W-1:0]   cnt;
  logic                cap_read, cap_write, cap_ill;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;

  logic                live_req, live_ill;
  logic                acc_read, acc_write, acc_ill, enter;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;

  assign live_req = req_read || req_write;
  assign live_ill = (req_read && req_write) || ({1'b0, req_addr} >= DEPTH_L);

  // With zero wait states the array is accessed on the accepting edge, so
  // the live request is used instead of the (not yet loaded) capture.
  always_comb begin
    acc_read  = cap_read;
    acc_write = cap_write;
    acc_ill   = cap_ill;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    enter     = 1'b0;
    if (state == ST_IDLE) begin
      acc_read  = req_read;
      acc_write = req_write;
      acc_ill   = live_ill;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      enter     = live_req && (WAIT_CYCLES == 0);
    end else if (state == ST_WAIT) begin
      enter = (cnt == WAIT_W'(1));
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      cap_read   <= 1'b0;
      cap_write  <= 1'b0;
      cap_ill    <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      resp_ready <= 1'b0;
      resp_err   <= 1'b0;
      resp_busy  <= 1'b0;
    end else begin
      resp_ready <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (live_req) begin
            cap_read  <= req_read;
            cap_write <= req_write;
            cap_ill   <= live_ill;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cnt       <= WAIT_W'(WAIT_CYCLES);
            resp_busy <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
            end else begin
              state      <= ST_RESPOND;
              resp_ready <= 1'b1;
              resp_err   <= live_ill;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - WAIT_W'(1);
          if (cnt == WAIT_W'(1)) begin
            state      <= ST_RESPOND;
            resp_ready <= 1'b1;
            resp_err   <= cap_ill;
          end
        end
        ST_RESPOND: begin
          state     <= ST_IDLE;
          resp_busy <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          resp_busy <= 1'b0;
        end
      endcase
    end
  end

  assign resp_state = state;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk   (CLK),
    .rst   (Reset),
    .we    (enter && acc_write && !acc_ill && !Reset),
    .re    (enter && acc_read && !acc_ill),
    .clr   (enter && acc_ill),
    .addr  (acc_addr[AW-1:0]),
    .wdata (acc_wdata),
    .rdata (resp_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) driven with
// directed and random accesses, compared against an array-based model.
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        rd_i   [2];
  logic        wr_i   [2];
  logic [15:0] addr_i [2];
  logic [15:0] wd_i   [2];
  logic [15:0] rdata_o[2];
  logic        ready_o[2];
  logic        err_o  [2];
  logic        busy_o [2];
  logic [1:0]  state_o[2];

  int errors = 0;
  int checks = 0;

  logic [15:0] mm      [2][1024];
  logic [15:0] last_rd [2];

  always #5 CLK = ~CLK;

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
    .CLK(CLK), .Reset(Reset), .req_read(rd_i[0]), .req_write(wr_i[0]),
    .req_addr(addr_i[0]), .req_wdata(wd_i[0]), .resp_rdata(rdata_o[0]),
    .resp_ready(ready_o[0]), .resp_err(err_o[0]), .resp_busy(busy_o[0]),
    .resp_state(state_o[0]));

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
    .CLK(CLK), .Reset(Reset), .req_read(rd_i[1]), .req_write(wr_i[1]),
    .req_addr(addr_i[1]), .req_wdata(wd_i[1]), .resp_rdata(rdata_o[1]),
    .resp_ready(ready_o[1]), .resp_err(err_o[1]), .resp_busy(busy_o[1]),
    .resp_state(state_o[1]));

  function automatic int waits(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // One complete access, checked for latency, busy span, err, data and pulse width.
  task automatic do_access(input int d, input bit rd, input bit wr,
                           input logic [15:0] a, input logic [15:0] wd);
    int lat, busyc;
    bit ill;
    logic [15:0] exp_rd;
    ill = (rd && wr) || (a >= 16'd1024);
    exp_rd = ill ? 16'h0000 : (rd ? mm[d][a[9:0]] : last_rd[d]);
    @(negedge CLK);
    checks++;
    if (state_o[d] !== 2'd0) begin
      errors++; $display("FAIL pre_idle d=%0d state=%0d required 0", d, state_o[d]);
    end
    rd_i[d] = rd; wr_i[d] = wr; addr_i[d] = a; wd_i[d] = wd;
    @(posedge CLK);
    @(negedge CLK);
    rd_i[d] = 1'b0; wr_i[d] = 1'b0;
    lat = 0; busyc = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) @(negedge CLK);
      if (busy_o[d] === 1'b1) busyc++;
      if (ready_o[d] === 1'b1) begin lat = cyc; break; end
    end
    checks++;
    if (lat != waits(d) + 1) begin
      errors++; $display("FAIL latency d=%0d addr=%h got=%0d required=%0d", d, a, lat, waits(d) + 1);
    end
    checks++;
    if (busyc != waits(d) + 1) begin
      errors++; $display("FAIL busy_span d=%0d got=%0d required=%0d", d, busyc, waits(d) + 1);
    end
    checks++;
    if (err_o[d] !== ill) begin
      errors++; $display("FAIL err d=%0d addr=%h got=%b required=%b", d, a, err_o[d], ill);
    end
    checks++;
    if (rdata_o[d] !== exp_rd) begin
      errors++; $display("FAIL rdata d=%0d addr=%h got=%h required=%h", d, a, rdata_o[d], exp_rd);
    end
    @(negedge CLK);
    checks++;
    if (ready_o[d] !== 1'b0 || busy_o[d] !== 1'b0 || err_o[d] !== 1'b0) begin
      errors++; $display("FAIL pulse_end d=%0d ready=%b busy=%b err=%b required 0", d, ready_o[d], busy_o[d], err_o[d]);
    end
    if (!ill && wr) mm[d][a[9:0]] = wd;
    last_rd[d] = exp_rd;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (state_o[d] !== 2'd0 || rdata_o[d] !== 16'h0 || ready_o[d] !== 1'b0 ||
          err_o[d] !== 1'b0 || busy_o[d] !== 1'b0) begin
        errors++; $display("FAIL reset d=%0d state=%0d rdata=%h ready=%b err=%b busy=%b required all 0",
                           d, state_o[d], rdata_o[d], ready_o[d], err_o[d], busy_o[d]);
      end
      last_rd[d] = 16'h0;
    end
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic test_preload();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 64; a++)
        do_access(d, 1'b0, 1'b1, 16'(a), 16'($urandom));
  endtask

  task automatic test_reset_mid_write();
    do_access(0, 1'b0, 1'b1, 16'h0005, 16'h0000);
    @(negedge CLK);
    wr_i[0] = 1'b1; addr_i[0] = 16'h0005; wd_i[0] = 16'hBEEF;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (state_o[0] !== 2'd1) begin
      errors++; $display("FAIL rst_wait_entry state=%0d required 1", state_o[0]);
    end
    Reset = 1'b1; wr_i[0] = 1'b0;
    #1;
    checks++;
    if (state_o[0] !== 2'd0 || busy_o[0] !== 1'b0 || ready_o[0] !== 1'b0 ||
        err_o[0] !== 1'b0 || rdata_o[0] !== 16'h0) begin
      errors++; $display("FAIL rst_abort state=%0d busy=%b ready=%b err=%b rdata=%h required all 0",
                         state_o[0], busy_o[0], ready_o[0], err_o[0], rdata_o[0]);
    end
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    @(negedge CLK);
    Reset = 1'b0;
    do_access(0, 1'b1, 1'b0, 16'h0005, 16'h0);
  endtask

  task automatic test_write_read_w2();
    do_access(0, 1'b0, 1'b1, 16'h0010, 16'hA5A5);
    do_access(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    checks++;
    if (rdata_o[0] !== 16'hA5A5) begin
      errors++; $display("FAIL raw_w2 got=%h required=a5a5", rdata_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_ready [4];
    logic [15:0] exp_data  [4];
    do_access(1, 1'b0, 1'b1, 16'h0001, 16'h1111);
    do_access(1, 1'b0, 1'b1, 16'h0002, 16'h2222);
    exp_ready = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_data  = '{16'h1111, 16'h1111, 16'h2222, 16'h2222};
    @(negedge CLK);
    rd_i[1] = 1'b1; addr_i[1] = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (i == 0) addr_i[1] = 16'h0002;
      if (i == 2) rd_i[1] = 1'b0;
      checks++;
      if (ready_o[1] !== exp_ready[i] || rdata_o[1] !== exp_data[i]) begin
        errors++; $display("FAIL b2b cyc=%0d ready=%b rdata=%h required ready=%b rdata=%h",
                           i, ready_o[1], rdata_o[1], exp_ready[i], exp_data[i]);
      end
    end
    last_rd[1] = 16'h2222;
  endtask

  task automatic test_illegal();
    for (int d = 0; d < 2; d++) begin
      do_access(d, 1'b1, 1'b1, 16'h0003, 16'hFFFF);
      do_access(d, 1'b1, 1'b0, 16'h0400, 16'h0);
      do_access(d, 1'b0, 1'b1, 16'h03FF, 16'h5A5A);
      do_access(d, 1'b1, 1'b0, 16'h03FF, 16'h0);
      do_access(d, 1'b1, 1'b0, 16'h0003, 16'h0);
    end
  endtask

  task automatic test_ignore_in_wait();
    int lat;
    do_access(0, 1'b0, 1'b1, 16'h0020, 16'h3C3C);
    do_access(0, 1'b0, 1'b1, 16'h0021, 16'h7777);
    @(negedge CLK);
    rd_i[0] = 1'b1; addr_i[0] = 16'h0020;
    @(posedge CLK);
    @(negedge CLK);
    addr_i[0] = 16'h0021; wr_i[0] = 1'b1; wd_i[0] = 16'hDEAD;
    lat = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc > 1) @(negedge CLK);
      if (ready_o[0] === 1'b1) begin lat = cyc; break; end
    end
    rd_i[0] = 1'b0; wr_i[0] = 1'b0;
    checks++;
    if (lat != 3 || rdata_o[0] !== 16'h3C3C || err_o[0] !== 1'b0) begin
      errors++; $display("FAIL ignore_wait lat=%0d rdata=%h err=%b required lat=3 rdata=3c3c err=0",
                         lat, rdata_o[0], err_o[0]);
    end
    last_rd[0] = 16'h3C3C;
    do_access(0, 1'b1, 1'b0, 16'h0021, 16'h0);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (busy_o[d] !== 1'b0 || ready_o[d] !== 1'b0 || state_o[d] !== 2'd0 ||
            rdata_o[d] !== last_rd[d]) begin
          errors++; $display("FAIL idle d=%0d busy=%b ready=%b state=%0d rdata=%h required 0/0/0/%h",
                             d, busy_o[d], ready_o[d], state_o[d], rdata_o[d], last_rd[d]);
        end
      end
    end
  endtask

  task automatic test_random();
    int sel;
    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < 2; d++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0)
          do_access(d, 1'b1, 1'b1, 16'($urandom_range(0, 63)), 16'($urandom));
        else if (sel == 1)
          do_access(d, 1'b1, 1'b0, 16'($urandom_range(1024, 65535)), 16'h0);
        else
          do_access(d, sel[0], !sel[0], 16'($urandom_range(0, 63)), 16'($urandom));
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_i[d] = 1'b0; wr_i[d] = 1'b0; addr_i[d] = 16'h0; wd_i[d] = 16'h0;
    end
    test_reset();
    test_preload();
    test_reset_mid_write();
    test_write_read_w2();
    test_back_to_back();
    test_illegal();
    test_ignore_in_wait();
    test_idle();
    test_random();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle processor's control unit.
- The control FSM issues read and write strobes; this block services them against an internal single-port word memory.
- Each access takes a configurable number of wait states, and completion is signalled by a one-cycle ready pulse.
- The block sits between the datapath address/write-data muxes (IoD path) and the instruction/data registers.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 16, request address width in bits; addresses are word-addressed.
- DEPTH, 1024, number of words in the memory array.
- WAIT_CYCLES, 2, wait states inserted before the response; legal range 0..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req_read  in  1  read request, level-sensitive.
- req_write  in  1  write request, level-sensitive.
- req_addr  in  ADDR_W  word address of the access.
- req_wdata  in  DATA_W  write data.
- resp_rdata  out  DATA_W  registered read data.
- resp_ready  out  1  one-cycle pulse: the access has completed.
- resp_err  out  1  one-cycle pulse, coincident with resp_ready: the access was illegal.
- resp_busy  out  1  high while an access is accepted and has not yet completed.
- resp_state  out  2  current FSM state, for debug.

Behaviour:
- FSM states: IDLE=0, WAIT=1, RESPOND=2; encoding 3 is unused and returns to IDLE.
- Reset, asynchronous, forces the following values:
  - state=IDLE, wait counter=0.
  - resp_rdata=0, resp_ready=0, resp_err=0, resp_busy=0.
  - The captured request is cleared.
  - Memory array contents are not reset.
- Reset asserted mid-access aborts the access. A pending write is discarded and the array is left unmodified.
- IDLE:
  - If req_read or req_write is high at the rising edge, capture addr, wdata, read/write and an illegal flag.
  - Load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go straight to RESPOND.
  - If neither request is high, stay in IDLE.
- Illegal access: req_read and req_write both high, or req_addr >= DEPTH.
- WAIT: decrement the counter each cycle; on the edge where the counter equals 1, go to RESPOND.
- Array access happens on the edge that enters RESPOND, using the captured request:
  - Legal write: the array word is updated.
  - Legal read: resp_rdata is loaded from the array.
  - Illegal access: no array change, and resp_rdata is loaded with 0.
- RESPOND:
  - resp_ready=1 for exactly one cycle; resp_err=1 in the same cycle if the access was illegal.
  - Then go to IDLE.
- Latency: resp_ready is high in cycle WAIT_CYCLES+1 after the accepting edge. This is 1 cycle when WAIT_CYCLES=0.
- resp_rdata holds its value until the next completed read or illegal access. Writes do not change resp_rdata.
- resp_busy is high in WAIT and in RESPOND.
- Request inputs are ignored outside IDLE, so changes during WAIT have no effect.
- Back-to-back: if a request is still high in the IDLE cycle after RESPOND, it is accepted as a new access. The minimum spacing is WAIT_CYCLES+2 cycles per access.
- Read-after-write to the same address returns the newly written data.

Decomposition:
- Package mem_responder_pkg holds:
  - state encodings IDLE/WAIT/RESPOND;
  - the DATA_W and ADDR_W defaults;
  - the WAIT_CYCLES width constant (4 bits).
- Sub-module mem_array: a single-port synchronous RAM with DEPTH×DATA_W, a write enable and a registered read.
  - The responder instantiates it and drives it only on the edge entering RESPOND.
- The FSM, counter and request capture stay in mem_responder.

Test Plan:
1. Reset during a WAIT write: write addr 0x0005 data 0xBEEF, assert Reset in the first WAIT cycle, then read 0x0005. Required: the state returns to IDLE immediately, all outputs are 0, and the read returns the prior contents (0x0000 after preload), not 0xBEEF.
2. WAIT_CYCLES=2 write then read: write addr 0x0010 data 0xA5A5, then read addr 0x0010. Required: resp_ready pulses exactly 3 cycles after each accept, resp_busy is high for 3 cycles, and resp_rdata=0xA5A5 after the read.
3. WAIT_CYCLES=0 back-to-back reads: hold req_read high with addresses 0x0001 then 0x0002, preloaded 0x1111/0x2222. Required: resp_ready pulses every 2 cycles, and resp_rdata goes 0x1111 then 0x2222.
4. Illegal requests: req_read and req_write both high at 0x0003, then a read of addr 0x0400 with DEPTH=1024. Required: each produces resp_ready=1 with resp_err=1 and resp_rdata=0x0000, and the array word at 0x0003 is unchanged.
5. Inputs ignored outside IDLE: start a read of 0x0020 (contents 0x3C3C), then during WAIT change req_addr to 0x0021 and raise req_write. Required: the response is 0x3C3C from 0x0020, and no write occurs at 0x0021.
6. No request: idle for 10 cycles with both requests low. Required: resp_busy=0, resp_ready=0, resp_state=0 throughout, and resp_rdata is unchanged.
